// File: rtl/div_32by16_signed.sv
// Sequential 32-by-16 signed divider: restoring radix-2 on magnitudes, one quotient
// bit per clock, sign correction and signed-overflow detection in the final state.
module div_32by16_signed (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] dvd,
    input  logic [15:0] dvs,
    output logic [15:0] quot,
    output logic [15:0] rem,
    output logic        ovf,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_ITER  = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        sq_q, sq_d;
    logic        sr_q, sr_d;
    logic        err_q, err_d;
    logic [31:0] ad_q, ad_d;
    logic [15:0] av_q, av_d;
    logic [15:0] prem_q, prem_d;
    logic [15:0] uq_q, uq_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] quot_q, quot_d;
    logic [15:0] rem_q, rem_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;

    // The remainder stays below av (<= 0x8000), so 16 bits hold it between
    // iterations; the 17-bit working value only exists during the trial subtract.
    logic [16:0] shifted;
    logic [16:0] trial;
    logic        fin_ovf;

    always_comb begin
        shifted = {prem_q, ad_q[4'd15 - cnt_q]};
        trial   = shifted - {1'b0, av_q};
        fin_ovf = err_q | (~sq_q & uq_q[15]) | (sq_q & (uq_q > 16'h8000));
    end

    always_comb begin
        state_d = state_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        err_d   = err_q;
        ad_d    = ad_q;
        av_d    = av_q;
        prem_d  = prem_q;
        uq_d    = uq_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    sq_d    = dvd[31] ^ dvs[15];
                    sr_d    = dvd[31];
                    ad_d    = dvd[31] ? -dvd : dvd;
                    av_d    = dvs[15] ? -dvs : dvs;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((av_q == 16'd0) || (ad_q[31:16] >= av_q)) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    err_d   = 1'b0;
                    prem_d  = ad_q[31:16];
                    uq_d    = '0;
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                // trial[16] set means the subtraction went negative: restore.
                prem_d = trial[16] ? shifted[15:0] : trial[15:0];
                uq_d   = {uq_q[14:0], ~trial[16]};
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = S_FIN;
                end
            end
            default: begin
                if (fin_ovf) begin
                    quot_d = '0;
                    rem_d  = '0;
                end else begin
                    quot_d = sq_q ? -uq_q : uq_q;
                    rem_d  = sr_q ? -prem_q : prem_q;
                end
                ovf_d   = fin_ovf;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            err_q   <= 1'b0;
            ad_q    <= '0;
            av_q    <= '0;
            prem_q  <= '0;
            uq_q    <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            err_q   <= err_d;
            ad_q    <= ad_d;
            av_q    <= av_d;
            prem_q  <= prem_d;
            uq_q    <= uq_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign quot = quot_q;
    assign rem  = rem_q;
    assign ovf  = ovf_q;
    assign done = done_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_32by16_signed.sv
// Self-checking bench for div_32by16_signed: directed cases from the divider's
// contract plus randomized operands against a plain-arithmetic reference model.
module tb_div_32by16_signed;

    logic        clk;
    logic        rst;
    logic        load;
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic [15:0] quot;
    logic [15:0] rem;
    logic        ovf;
    logic        busy;
    logic        done;

    int n_cmp;
    int n_err;

    div_32by16_signed dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .dvd  (dvd),
        .dvs  (dvs),
        .quot (quot),
        .rem  (rem),
        .ovf  (ovf),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: language division truncates toward zero and the remainder follows
    // the dividend's sign. Errors found up front (zero divisor or |q| >= 2^16)
    // finish in 2 clocks; everything else takes the full 18.
    function automatic void model(input logic signed [31:0] a, input logic signed [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic o, output int lat);
        longint la, lb, lq, lr;
        la = a;
        lb = b;
        if (lb == 0) begin
            q = '0; r = '0; o = 1'b1; lat = 2;
        end else begin
            lq  = la / lb;
            lr  = la % lb;
            lat = (lq >= 65536 || lq <= -65536) ? 2 : 18;
            if (lq > 32767 || lq < -32768) begin
                q = '0; r = '0; o = 1'b1;
            end else begin
                q = lq[15:0]; r = lr[15:0]; o = 1'b0;
            end
        end
    endfunction

    // chain=1 drives load immediately (caller is just past a done edge);
    // poke>0 pulses a stray load that many clocks into the divide.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [15:0] b,
                           input bit chain, input int poke);
        logic [15:0] eq, er;
        logic        eo;
        int          elat;
        int          lat;
        model(a, b, eq, er, eo, elat);
        if (!chain) @(negedge clk);
        dvd  = a;
        dvs  = b;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        dvd  = $urandom;
        dvs  = 16'($urandom);
        check({tag, "_busy_rise"}, {31'b0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (poke != 0 && lat == poke) begin
                load = 1'b1;
                dvd  = 32'd1000;
                dvs  = 16'd3;
            end else begin
                load = 1'b0;
            end
        end
        load = 1'b0;
        check({tag, "_lat"},  lat, elat);
        check({tag, "_quot"}, {16'b0, quot}, {16'b0, eq});
        check({tag, "_rem"},  {16'b0, rem},  {16'b0, er});
        check({tag, "_ovf"},  {31'b0, ovf},  {31'b0, eo});
        check({tag, "_busy_fall"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] ra;
        logic [15:0] rb;
        n_cmp = 0;
        n_err = 0;
        rst  = 1'b1;
        load = 1'b0;
        dvd  = '0;
        dvs  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_quot", {16'b0, quot}, 32'd0);
        check("reset_rem",  {16'b0, rem},  32'd0);
        check("reset_ovf",  {31'b0, ovf},  32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        rst = 1'b0;

        run_div("inv_mult",  32'd184320, 16'd288, 1'b0, 0);
        run_div("neg_exact", -32'sd57344, 16'd448, 1'b0, 0);
        run_div("neg_dvd",   -32'sd7, 16'd2, 1'b0, 0);
        run_div("neg_dvs",   32'd7, -16'sd2, 1'b0, 0);
        run_div("min_quot",  -32'sd1073709056, 16'd32767, 1'b0, 0);
        run_div("max_quot",  -32'sd1073709056, 16'h8000, 1'b0, 0);
        run_div("min_min",   32'h8000_0000, 16'h8000, 1'b0, 0);
        run_div("zero_dvs",  32'd123456, 16'd0, 1'b0, 0);
        run_div("mag_ovf",   32'd65536, 16'd1, 1'b0, 0);
        run_div("fin_ovf",   32'd32768, 16'd1, 1'b0, 0);
        run_div("pos_small", 32'd100, 16'd7, 1'b0, 0);

        run_div("ignored_load", 32'd184320, 16'd288, 1'b0, 5);
        run_div("b2b_first",    -32'sd7, 16'd2, 1'b0, 0);
        run_div("b2b_second",   32'd184320, 16'd288, 1'b1, 0);

        // Abort a divide at clock 9; outputs must clear before the next edge.
        @(negedge clk);
        dvd  = 32'd184320;
        dvs  = 16'd288;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_quot", {16'b0, quot}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("arst_no_done", seen, 0);
        run_div("after_rst", 32'd11245773, 16'd2937, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = 16'($urandom);
            if (i % 3 != 0) ra = $signed(ra) >>> $urandom_range(0, 20);
            if (i % 4 == 1) rb = $signed(rb) >>> $urandom_range(0, 12);
            if (i % 13 == 7) rb = '0;
            run_div("random", ra, rb, 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
